// File: rtl/fpga_bridge_send_vc.sv
// Credit-based virtual-channel sender: round-robin arbitration among
// NUM_CH flit streams, per-channel credits, flit-to-beat serialisation.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bin_data      : NUM_CH flits, channel i at [i*NOC_WIDTH +: NOC_WIDTH]
//   bin_val       : flit valid per channel
//   bin_rdy       : combinational accept, one-hot winner in accept window
//   link_data     : registered beat, least-significant word first
//   link_val      : beat valid
//   link_channel  : channel index of the current beat
//   credit_back   : one-cycle pulse per channel returning one credit
//   credit_cnt    : current credit count per channel
//   credit_err    : sticky, credit returned while counter already full
module fpga_bridge_send_vc #(
    parameter int          NUM_CH      = 3,
    parameter int          CH_W        = 2,
    parameter int          NOC_WIDTH   = 64,
    parameter int          LINK_WIDTH  = 32,
    parameter int          CNT_W       = 9,
    parameter int unsigned CREDIT_INIT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*NOC_WIDTH-1:0] bin_data,
    input  logic [NUM_CH-1:0]           bin_val,
    output logic [NUM_CH-1:0]           bin_rdy,
    output logic [LINK_WIDTH-1:0]       link_data,
    output logic                        link_val,
    output logic [CH_W-1:0]             link_channel,
    input  logic [NUM_CH-1:0]           credit_back,
    output logic [NUM_CH*CNT_W-1:0]     credit_cnt,
    output logic                        credit_err
);

    localparam int BEATS = NOC_WIDTH / LINK_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BW-1:0]    LAST = BW'(BEATS - 1);
    localparam logic [CNT_W-1:0] INIT = CNT_W'(CREDIT_INIT);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                r_state;
    logic [BW-1:0]         r_beat;
    logic [NOC_WIDTH-1:0]  r_flit;
    logic [CH_W-1:0]       r_ptr;
    logic [CNT_W-1:0]      r_cnt [NUM_CH];
    logic                  r_err;
    logic [LINK_WIDTH-1:0] r_link_data;
    logic                  r_link_val;
    logic [CH_W-1:0]       r_link_ch;

    logic [NUM_CH-1:0]     w_elig;
    logic [NUM_CH-1:0]     w_rdy;
    logic [NUM_CH-1:0]     w_take;
    logic                  w_win;
    logic                  w_found;
    logic                  w_acc;
    logic [CH_W-1:0]       w_gnt;
    logic [NOC_WIDTH-1:0]  w_flit;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_elig[i] = bin_val[i] && (r_cnt[i] != '0);
        end
    end

    // A new flit may be taken when the link is idle or showing its last beat.
    assign w_win = (r_state == S_IDLE) || (r_beat == LAST);

    // Round-robin search starting one past the last winner.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            if (!w_found && w_elig[(int'(r_ptr) + off) % NUM_CH]) begin
                w_found = 1'b1;
                w_gnt   = CH_W'((int'(r_ptr) + off) % NUM_CH);
            end
        end
    end

    always_comb begin
        w_rdy  = '0;
        w_flit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt == CH_W'(i)) begin
                w_flit = bin_data[i*NOC_WIDTH +: NOC_WIDTH];
                // rst gating keeps bin_rdy low as soon as reset asserts.
                w_rdy[i] = w_win && w_found && !rst;
            end
        end
    end

    assign w_take = w_rdy & bin_val;
    assign w_acc  = |w_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_flit      <= '0;
            r_ptr       <= CH_W'(NUM_CH - 1);
            r_link_data <= '0;
            r_link_val  <= 1'b0;
            r_link_ch   <= '0;
        end else if (w_acc) begin
            r_state     <= S_SEND;
            r_beat      <= '0;
            r_flit      <= w_flit >> LINK_WIDTH;
            r_ptr       <= w_gnt;
            r_link_data <= w_flit[LINK_WIDTH-1:0];
            r_link_val  <= 1'b1;
            r_link_ch   <= w_gnt;
        end else if (r_state == S_SEND && r_beat != LAST) begin
            r_beat      <= r_beat + 1'b1;
            r_flit      <= r_flit >> LINK_WIDTH;
            r_link_data <= r_flit[LINK_WIDTH-1:0];
        end else begin
            r_state     <= S_IDLE;
            r_link_val  <= 1'b0;
        end
    end

    // Accept and return in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= INIT;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_take[i] && !credit_back[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end else if (!w_take[i] && credit_back[i]) begin
                    if (r_cnt[i] == INIT) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            credit_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign bin_rdy      = w_rdy;
    assign link_data    = r_link_data;
    assign link_val     = r_link_val;
    assign link_channel = r_link_ch;
    assign credit_err   = r_err;

endmodule
